// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed word frame, writes it into the control
// stage's program memory, starts a run and hands back the result. Optional macro: PROG_LOADER_CHECKSUM_EN.
module prog_loader (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        ctl_wr,
  output logic [9:0]  ctl_addr,
  output logic [15:0] ctl_datain,
  output logic        ctl_start,
  input  logic        ctl_ready,
  input  logic [15:0] ctl_out,
  output logic        res_valid,
  output logic [15:0] res_data,
  input  logic        res_ack,
  output logic        busy,
  output logic        err
);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_W_LO, S_W_HI, S_WRITE, S_START,
    S_WAIT_LOW, S_WAIT_HIGH, S_DONE, S_ERR, S_CHK
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_W_LO, S_W_HI, S_WRITE, S_START,
    S_WAIT_LOW, S_WAIT_HIGH, S_DONE, S_ERR
  } state_t;
`endif

  state_t      state, state_nx;
  logic [7:0]  len_lo;
  logic [9:0]  len;
  logic [9:0]  idx;
  logic [7:0]  lo, hi;
  logic        take;
  logic [15:0] n_full;
  logic        len_bad;
  logic        more;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign take    = in_valid & in_ready;
  assign n_full  = {in_data, len_lo};
  assign len_bad = (n_full == 16'd0) || (n_full > 16'd1000);
  assign more    = ({1'b0, idx} + 11'd1) < {1'b0, len};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:      if (take) state_nx = S_LEN_HI;
      S_LEN_HI:    if (take) state_nx = len_bad ? S_ERR : S_W_LO;
      S_W_LO:      if (take) state_nx = S_W_HI;
      S_W_HI:      if (take) state_nx = S_WRITE;
      S_WRITE: begin
        if (ctl_ready) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_nx = more ? S_W_LO : S_CHK;
`else
          state_nx = more ? S_W_LO : S_START;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:       if (take) state_nx = (in_data == csum) ? S_START : S_ERR;
`endif
      S_START:     state_nx = S_WAIT_LOW;
      S_WAIT_LOW:  if (!ctl_ready) state_nx = S_WAIT_HIGH;
      S_WAIT_HIGH: if (ctl_ready) state_nx = S_DONE;
      S_DONE:      if (res_ack) state_nx = S_IDLE;
      S_ERR:       if (res_ack) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    ctl_wr     = 1'b0;
    ctl_start  = 1'b0;
    res_valid  = 1'b0;
    err        = 1'b0;
    busy       = (state != S_IDLE);
    ctl_addr   = idx;
    ctl_datain = {hi, lo};
    unique case (state)
      S_IDLE, S_LEN_HI, S_W_LO, S_W_HI: in_ready = nrst;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:   in_ready = nrst;
`endif
      S_WRITE: ctl_wr    = ctl_ready;
      S_START: ctl_start = 1'b1;
      S_DONE:  res_valid = 1'b1;
      S_ERR:   err       = 1'b1;
      default: ;
    endcase
  end

  // idx only advances while more words follow, so it never leaves 0..len-1
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      len_lo   <= '0;
      len      <= '0;
      idx      <= '0;
      lo       <= '0;
      hi       <= '0;
      res_data <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: if (take) begin
          len_lo <= in_data;
          idx    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum   <= in_data;
`endif
        end
        S_LEN_HI: if (take) begin
          len  <= n_full[9:0];
`ifdef PROG_LOADER_CHECKSUM_EN
          csum <= csum ^ in_data;
`endif
        end
        S_W_LO: if (take) begin
          lo   <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum <= csum ^ in_data;
`endif
        end
        S_W_HI: if (take) begin
          hi   <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum <= csum ^ in_data;
`endif
        end
        S_WRITE:     if (ctl_ready && more) idx <= idx + 10'd1;
        S_WAIT_HIGH: if (ctl_ready) res_data <= ctl_out;
        S_DONE, S_ERR: if (res_ack) idx <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: frames are generated, a control-stage model executes
// the loaded program, and writes/results are compared to a frame-level reference model.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        ctl_wr, ctl_start, ctl_ready;
  logic [9:0]  ctl_addr;
  logic [15:0] ctl_datain, ctl_out;
  logic        res_valid, res_ack, busy, err;
  logic [15:0] res_data;
  logic        stall, calc_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign ctl_ready = ~stall & ~calc_busy;

  prog_loader dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ctl_wr(ctl_wr), .ctl_addr(ctl_addr), .ctl_datain(ctl_datain),
    .ctl_start(ctl_start), .ctl_ready(ctl_ready), .ctl_out(ctl_out),
    .res_valid(res_valid), .res_data(res_data), .res_ack(res_ack),
    .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stack calculator run by the control stage: bit15=0 pushes, 0x8002 adds, 0xC000 halts.
  function automatic logic [15:0] calc(input logic [15:0] w[$]);
    logic [15:0] st[$];
    logic [15:0] a, b;
    foreach (w[i]) begin
      if (!w[i][15]) st.push_back(w[i]);
      else if (w[i] == 16'hC000) break;
      else if (w[i] == 16'h8002 && st.size() >= 2) begin
        a = st.pop_back();
        b = st.pop_back();
        st.push_back(a + b);
      end
    end
    return (st.size() > 0) ? st[st.size()-1] : 16'h0000;
  endfunction

  typedef struct { logic [9:0] a; logic [15:0] d; } wr_t;
  wr_t         wr_q[$];
  int          starts, overlap;
  logic [15:0] mem [1024];
  int          last_addr;

  always @(negedge clk) begin
    if (ctl_wr) begin
      wr_q.push_back('{ctl_addr, ctl_datain});
      mem[ctl_addr] = ctl_datain;
      last_addr = int'(ctl_addr);
    end
    if (ctl_start) starts++;
    if (ctl_wr && ctl_start) overlap++;
  end

  initial begin
    logic [15:0] prog[$];
    calc_busy = 1'b0;
    ctl_out   = '0;
    forever begin
      @(negedge clk);
      if (ctl_start) begin
        prog.delete();
        for (int i = 0; i <= last_addr; i++) prog.push_back(mem[i]);
        @(posedge clk); #1 calc_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        ctl_out   = calc(prog);
        calc_busy = 1'b0;
      end
    end
  end

  // Called and returns at posedge+1; noise adds ctl_ready stalls and stray res_ack.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise, output bit ok);
    repeat (gap) begin
      @(posedge clk); #1;
      if (noise) begin stall = ($urandom_range(0, 2) == 0); res_ack = ($urandom_range(0, 3) == 0); end
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      if (noise) begin stall = ($urandom_range(0, 2) == 0); res_ack = ($urandom_range(0, 3) == 0); end
    end
    if (ok) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    res_ack  = 1'b0;
    if (noise) stall = ($urandom_range(0, 2) == 0);
  endtask

  task automatic ack_and_idle(input string tag);
    @(posedge clk); #1 res_ack = 1'b1;
    @(posedge clk); #1 res_ack = 1'b0;
    @(negedge clk);
    check({tag, "_busy_after_ack"}, busy, 0);
    check({tag, "_valid_after_ack"}, res_valid, 0);
    check({tag, "_err_after_ack"}, err, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_all(input logic [7:0] bytes[$], input int gapmax, input bit noise);
    bit ok;
    foreach (bytes[i]) begin
      send_byte(bytes[i], $urandom_range(0, gapmax), noise, ok);
      if (!ok) begin check("byte_accept", ok, 1); break; end
    end
    stall = 1'b0;
  endtask

  function automatic void frame_bytes(input logic [15:0] words[$], output logic [7:0] bytes[$]);
    int n;
    n = words.size();
    bytes.delete();
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    foreach (words[i]) begin
      bytes.push_back(words[i][7:0]);
      bytes.push_back(words[i][15:8]);
    end
  endfunction

  task automatic run_frame(input string tag, input logic [15:0] words[$], input int gapmax, input bit noise);
    logic [7:0]  bytes[$];
    logic [15:0] exp_res, r0;
    bit          got;
    int          bad;
    frame_bytes(words, bytes);
`ifdef PROG_LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = '0;
      foreach (bytes[i]) x ^= bytes[i];
      bytes.push_back(x);
    end
`endif
    wr_q.delete(); starts = 0; overlap = 0;
    send_all(bytes, gapmax, noise);
    exp_res = calc(words);
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (res_valid) begin got = 1'b1; break; end
    end
    check({tag, "_res_valid"}, got, 1);
    check({tag, "_res_data"}, res_data, exp_res);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_starts"}, starts, 1);
    check({tag, "_wr_start_overlap"}, overlap, 0);
    check({tag, "_wr_count"}, wr_q.size(), words.size());
    bad = 0;
    foreach (wr_q[i])
      if (i < words.size() && (wr_q[i].a != 10'(i) || wr_q[i].d != words[i])) bad++;
    check({tag, "_wr_bad"}, bad, 0);
    r0 = res_data;
    repeat (3) @(negedge clk);
    check({tag, "_res_stable"}, {res_valid, res_data}, {1'b1, r0});
    ack_and_idle(tag);
  endtask

  task automatic err_frame(input string tag, input logic [7:0] lo_b, input logic [7:0] hi_b);
    logic [7:0] bytes[$];
    bytes = '{lo_b, hi_b};
    wr_q.delete(); starts = 0;
    send_all(bytes, 1, 1'b0);
    @(negedge clk);
    check({tag, "_err"}, err, 1);
    check({tag, "_busy"}, busy, 1);
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) @(negedge clk);
    check({tag, "_ignores_bytes"}, {in_ready, err}, {1'b0, 1'b1});
    @(posedge clk); #1 in_valid = 1'b0;
    check({tag, "_no_wr"}, wr_q.size(), 0);
    check({tag, "_no_start"}, starts, 0);
    ack_and_idle(tag);
  endtask

  initial begin
    logic [15:0] words[$];
    logic [15:0] d31[$];
    logic [7:0]  bytes[$];
    in_valid = 1'b0; in_data = '0; res_ack = 1'b0; stall = 1'b0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {in_ready, ctl_wr, ctl_addr, ctl_datain, ctl_start, res_valid, res_data, busy, err}, 48'h0);
    @(posedge clk); #1 nrst = 1'b1;
    @(negedge clk);
    check("idle_ready", {in_ready, busy, err}, 3'b100);
    @(posedge clk); #1;

    d31 = '{16'h0003, 16'h0004, 16'h8002, 16'hC000};
    run_frame("basic", d31, 0, 1'b0);
    check("basic_wr3", {wr_q[3].a, wr_q[3].d}, {10'd3, 16'hC000});
    check("basic_wr2", {wr_q[2].a, wr_q[2].d}, {10'd2, 16'h8002});
    check("basic_const_res", calc(d31), 16'h0007);

    run_frame("gaps_stalls", d31, 3, 1'b1);

    err_frame("len0", 8'h00, 8'h00);
    err_frame("len1001", 8'hE9, 8'h03);
    err_frame("len_big", 8'($urandom), 8'($urandom_range(4, 255)));

    // Reset mid-frame after 5 bytes, then a clean resend.
    frame_bytes(d31, bytes);
    while (bytes.size() > 5) void'(bytes.pop_back());
    send_all(bytes, 0, 1'b0);
    nrst = 1'b0;
    @(negedge clk);
    check("midreset_outputs",
          {in_ready, ctl_wr, ctl_addr, ctl_datain, ctl_start, res_valid, res_data, busy, err}, 48'h0);
    @(posedge clk); #1 nrst = 1'b1;
    wr_q.delete();
    repeat (3) @(negedge clk);
    check("midreset_no_stray_wr", wr_q.size(), 0);
    check("midreset_idle", {in_ready, busy}, 2'b10);
    @(posedge clk); #1;
    run_frame("after_reset", d31, 0, 1'b0);

    words = '{16'h1234};
    run_frame("n1", words, 1, 1'b1);

    for (int f = 0; f < 10; f++) begin
      words.delete();
      for (int i = 0; i < $urandom_range(1, 12); i++)
        words.push_back(($urandom_range(0, 3) == 0) ? 16'h8002 : 16'($urandom & 32'h7FFF));
      run_frame($sformatf("rand%0d", f), words, 2, 1'b1);
    end

    words.delete();
    for (int i = 0; i < 1000; i++) words.push_back(16'($urandom));
    run_frame("n1000", words, 0, 1'b0);
    check("n1000_last_addr", wr_q[wr_q.size()-1].a, 10'd999);

`ifdef PROG_LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      frame_bytes(d31, bytes);
      x = '0;
      foreach (bytes[i]) x ^= bytes[i];
      bytes.push_back(x ^ 8'h01);
      wr_q.delete(); starts = 0;
      send_all(bytes, 0, 1'b0);
      repeat (3) @(negedge clk);
      check("csum_bad_err", err, 1);
      check("csum_bad_no_start", starts, 0);
      ack_and_idle("csum_bad");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
